uart_tx_framer: RTL and testbench
=================================

UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 SHALL have parameter BAUD_PRESCALER, default 200, clocks per serial bit (>=2).
REQ-002 SHALL have parameter CHARS, default 4, characters per transfer (1..8).
REQ-003 SHALL have parameter DATA_BITS, default 8, bits per character (5..8).
REQ-004 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-005 SHALL have parameter STOP_BITS, default 1, stop bits per character (1 or 2).
REQ-006 SHALL have i_clk  input  1  sole clock; one clock domain.
REQ-007 SHALL have i_rst  input  1  reset; synchronous, active-high.
REQ-008 SHALL have i_data  input  CHARS*DATA_BITS  transfer payload; character k = i_data[k*DATA_BITS +: DATA_BITS].
REQ-009 SHALL have i_valid  input  1  payload offered.
REQ-010 SHALL have o_ready  output  1  block accepts a payload this cycle.
REQ-011 SHALL have o_busy  output  1  transfer in progress.
REQ-012 SHALL have o_done  output  1  one-cycle pulse at transfer end.
REQ-013 SHALL have o_tx  output  1  serial line, idle high.

Function
REQ-014 Handshake: payload accepted on the rising i_clk edge where i_valid && o_ready; i_data captured into an internal register at that edge; later i_data changes are ignored.
REQ-015 o_ready SHALL be 1 only in IDLE and not in reset; o_busy SHALL equal !o_ready outside reset.
REQ-016 FSM states: IDLE, START, DATA, PAR, STOP; every non-IDLE bit state lasts exactly BAUD_PRESCALER clocks, timed by a baud counter cleared on each state entry.
REQ-017 IDLE -> START on accept; o_tx SHALL go low on the first cycle after the accept edge (latency 1).
REQ-018 START (o_tx=0) -> DATA; DATA drives character bits LSB first, DATA_BITS bit periods, character 0 first.
REQ-019 DATA -> PAR if PARITY!=0, else -> STOP; PAR drives XOR of character bits (even) or its inverse (odd).
REQ-020 STOP drives o_tx=1 for STOP_BITS bit periods; then -> START for next character if characters remain, else -> IDLE.
REQ-021 No idle gap between characters of one transfer; minimum one IDLE cycle (o_ready=1) between transfers.
REQ-022 o_done SHALL pulse high for exactly the one cycle on which the FSM enters IDLE from STOP.
REQ-023 Transfer length SHALL be CHARS*(1+DATA_BITS+(PARITY!=0)+STOP_BITS)*BAUD_PRESCALER clocks from first low o_tx cycle to IDLE entry.
REQ-024 Counters: baud counter $clog2(BAUD_PRESCALER) bits, bit index $clog2(DATA_BITS+1), character index $clog2(CHARS+1); no wrap before terminal compare.
REQ-025 i_valid while busy SHALL be ignored without side effect.

Reset
REQ-026 i_rst high at any edge, including mid-character, SHALL force IDLE, o_tx=1, o_ready=0 during reset, o_busy=0, o_done=0, all counters 0.
REQ-027 First cycle after i_rst deasserts SHALL have o_ready=1 and o_tx=1.
REQ-028 Aborted transfer SHALL not resume and SHALL not pulse o_done.

Structure
REQ-029 State encoding and parity-mode constants (PAR_NONE, PAR_EVEN, PAR_ODD) SHALL live in a shared package uart_pkg.
REQ-030 One sub-module, uart_baud_counter (run/clear in, terminal tick out), SHALL generate bit timing.
REQ-031 All sequential logic SHALL be clocked by i_clk only; no derived clocks.

Verification (BAUD_PRESCALER=4 unless stated)
REQ-032 CHARS=1, DATA_BITS=8, PARITY=0, i_data=0x55 -> o_tx 0,1,0,1,0,1,0,1,0,1 each 4 clocks, o_done at clock 41 after accept.
REQ-033 CHARS=2, PARITY=1, i_data=0x0301 -> char0 parity 1, char1 parity 0; no gap between chars; length 2*11*4=88 clocks.
REQ-034 PARITY=2, STOP_BITS=2, DATA_BITS=7, i_data=0x00 -> parity bit 1, stop high 8 clocks.
REQ-035 i_valid held high continuously with CHARS=1 -> second transfer starts exactly one cycle after o_done; i_data change while busy does not alter output.
REQ-036 i_rst asserted during DATA bit 3 of char 1 -> next cycle o_tx=1, o_busy=0, no o_done; new transfer after release is bit-exact.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the UART transmit framer: the framer FSM state
//   encoding, the parity-mode constants used for the PARITY parameter, and a
//   helper that produces the parity bit for a character.
package uart_pkg;

  // Framer states; every state other than IDLE is one or more bit periods long.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } tx_state_e;

  // Parity modes selected by the PARITY parameter.
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Parity bit for a character zero-extended to 8 bits. Even parity sends the
  // XOR of the data bits so the total count of ones is even; odd inverts it.
  function automatic logic parity_bit(input logic [7:0] ch, input int mode);
    logic p;
    p = ^ch;
    if (mode == PAR_ODD) begin
      p = ~p;
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// uart_baud_counter
//   Bit-period timer for the UART framer. While running it counts clocks and
//   raises o_tick on the last clock of each BAUD_PRESCALER-clock bit period,
//   wrapping to zero on that same edge so the next period starts cleanly.
//
// Ports
//   i_clk   : clock
//   i_rst   : synchronous active-high reset, clears the count
//   i_run   : count enable; the count is held at zero while low
//   i_clear : forces the count back to zero
//   o_tick  : high during the final clock of a bit period
module uart_baud_counter #(
  parameter int BAUD_PRESCALER = 200
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_run,
  input  logic i_clear,
  output logic o_tick
);

  localparam int CNT_W = $clog2(BAUD_PRESCALER);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BAUD_PRESCALER - 1);

  logic [CNT_W-1:0] cnt;

  assign o_tick = i_run && (cnt == LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear || !i_run) begin
      cnt <= '0;
    end else if (o_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_framer.sv
// uart_tx_framer
//   Serialises a multi-character payload onto a UART line. Each character is
//   sent as a start bit, DATA_BITS data bits LSB first, an optional parity
//   bit and STOP_BITS stop bits, each bit lasting BAUD_PRESCALER clocks.
//   Characters of one transfer follow back to back with character 0 first.
//
// Ports
//   i_clk   : sole clock
//   i_rst   : synchronous active-high reset; aborts any transfer
//   i_data  : payload, character k = i_data[k*DATA_BITS +: DATA_BITS]
//   i_valid : payload offered; accepted when o_ready is also high
//   o_ready : idle and able to accept a payload this cycle
//   o_busy  : transfer in progress
//   o_done  : one-cycle pulse on return to idle after the last stop bit
//   o_tx    : serial line, idle high
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int BAUD_PRESCALER = 200,
  parameter int CHARS          = 4,
  parameter int DATA_BITS      = 8,
  parameter int PARITY         = PAR_NONE,
  parameter int STOP_BITS      = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [CHARS*DATA_BITS-1:0] i_data,
  input  logic                       i_valid,
  output logic                       o_ready,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_tx
);

  localparam int BIT_W  = $clog2(DATA_BITS + 1);
  localparam int CHAR_W = $clog2(CHARS + 1);

  localparam logic [BIT_W-1:0]  LAST_DATA = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  LAST_STOP = BIT_W'(STOP_BITS - 1);
  localparam logic [CHAR_W-1:0] LAST_CHAR = CHAR_W'(CHARS - 1);

  tx_state_e                  state;
  logic [CHARS*DATA_BITS-1:0] data_q;    // captured payload, current char in low bits
  logic [DATA_BITS-1:0]       shreg;     // remaining data bits of current char
  logic [BIT_W-1:0]           bit_idx;   // data bit index, reused for stop bits
  logic [CHAR_W-1:0]          char_idx;
  logic                       tick;
  logic [DATA_BITS-1:0]       cur_char;

  assign cur_char = data_q[DATA_BITS-1:0];

  // Ready/busy follow the state directly so the cycle right after reset is
  // released already reports ready, and both drop while reset is held.
  assign o_ready = (state == IDLE) && !i_rst;
  assign o_busy  = (state != IDLE) && !i_rst;

  // State changes happen only on a tick (where the counter wraps to zero) or
  // out of IDLE (where the counter is held clear), so every state is entered
  // with a zero count and lasts exactly one prescaler period per bit.
  uart_baud_counter #(
    .BAUD_PRESCALER(BAUD_PRESCALER)
  ) u_baud (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_run  (state != IDLE),
    .i_clear(state == IDLE),
    .o_tick (tick)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      data_q   <= '0;
      shreg    <= '0;
      bit_idx  <= '0;
      char_idx <= '0;
      o_tx     <= 1'b1;
      o_done   <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          o_tx <= 1'b1;
          if (i_valid) begin
            data_q   <= i_data;
            bit_idx  <= '0;
            char_idx <= '0;
            state    <= START;
            o_tx     <= 1'b0;
          end
        end

        START: begin
          if (tick) begin
            state   <= DATA;
            bit_idx <= '0;
            o_tx    <= cur_char[0];
            shreg   <= cur_char >> 1;
          end
        end

        DATA: begin
          if (tick) begin
            if (bit_idx == LAST_DATA) begin
              bit_idx <= '0;
              if (PARITY != PAR_NONE) begin
                state <= PAR;
                o_tx  <= parity_bit(8'(cur_char), PARITY);
              end else begin
                state <= STOP;
                o_tx  <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + BIT_W'(1);
              o_tx    <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end
        end

        PAR: begin
          if (tick) begin
            state   <= STOP;
            bit_idx <= '0;
            o_tx    <= 1'b1;
          end
        end

        STOP: begin
          if (tick) begin
            if (bit_idx == LAST_STOP) begin
              bit_idx <= '0;
              if (char_idx == LAST_CHAR) begin
                state    <= IDLE;
                char_idx <= '0;
                o_done   <= 1'b1;
                o_tx     <= 1'b1;
              end else begin
                // Next character moves into the low bits; start bit follows
                // the last stop bit with no idle gap.
                state    <= START;
                char_idx <= char_idx + CHAR_W'(1);
                data_q   <= data_q >> DATA_BITS;
                o_tx     <= 1'b0;
              end
            end else begin
              bit_idx <= bit_idx + BIT_W'(1);
            end
          end
        end

        default: begin
          state <= IDLE;
          o_tx  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb_uart_tx_framer
//   Three framer instances with different framing options share one clock
//   and reset. Expected line levels come from an arithmetic model that maps
//   a cycle offset after the accept edge to a bit position within a frame.
module tb_uart_tx_framer;

  localparam int BP     = 4;
  localparam int CH [3] = '{1, 2, 1};
  localparam int DB [3] = '{8, 8, 7};
  localparam int PR [3] = '{0, 1, 2};
  localparam int SB [3] = '{1, 1, 2};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  valid = '0;
  logic [7:0]  din0 = '0;
  logic [15:0] din1 = '0;
  logic [6:0]  din2 = '0;
  wire  [2:0]  ready, busy, done, tx;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_tx_framer #(.BAUD_PRESCALER(BP), .CHARS(CH[0]), .DATA_BITS(DB[0]),
                   .PARITY(PR[0]), .STOP_BITS(SB[0])) u0 (
    .i_clk(clk), .i_rst(rst), .i_data(din0), .i_valid(valid[0]),
    .o_ready(ready[0]), .o_busy(busy[0]), .o_done(done[0]), .o_tx(tx[0]));

  uart_tx_framer #(.BAUD_PRESCALER(BP), .CHARS(CH[1]), .DATA_BITS(DB[1]),
                   .PARITY(PR[1]), .STOP_BITS(SB[1])) u1 (
    .i_clk(clk), .i_rst(rst), .i_data(din1), .i_valid(valid[1]),
    .o_ready(ready[1]), .o_busy(busy[1]), .o_done(done[1]), .o_tx(tx[1]));

  uart_tx_framer #(.BAUD_PRESCALER(BP), .CHARS(CH[2]), .DATA_BITS(DB[2]),
                   .PARITY(PR[2]), .STOP_BITS(SB[2])) u2 (
    .i_clk(clk), .i_rst(rst), .i_data(din2), .i_valid(valid[2]),
    .o_ready(ready[2]), .o_busy(busy[2]), .o_done(done[2]), .o_tx(tx[2]));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  task automatic set_din(input int d, input logic [63:0] v);
    case (d)
      0:       din0 = v[7:0];
      1:       din1 = v[15:0];
      default: din2 = v[6:0];
    endcase
  endtask

  // Line level t cycles after the accept edge (t=0 is the first cycle after it).
  function automatic logic exp_tx(input int t, input logic [63:0] data,
                                  input int chars, input int db, input int par,
                                  input int stop);
    int frame, bitpos, ch, k;
    logic [63:0] c;
    frame  = 1 + db + ((par != 0) ? 1 : 0) + stop;
    bitpos = t / BP;
    ch     = bitpos / frame;
    k      = bitpos % frame;
    if (ch >= chars) return 1'b1;
    c = (data >> (ch * db)) & ((64'd1 << db) - 64'd1);
    if (k == 0) return 1'b0;
    if (k <= db) return c[k-1];
    if (par != 0 && k == db + 1) return (^c) ^ (par == 2);
    return 1'b1;
  endfunction

  // Offers one payload to instance d and follows it to completion. With hold
  // set, i_valid stays high afterwards. abort_at >= 0 raises reset at that
  // cycle offset and then checks the line stays idle.
  task automatic run_xfer(input int d, input logic [63:0] data, input bit hold,
                          input int abort_at);
    int len;
    len = CH[d] * (1 + DB[d] + ((PR[d] != 0) ? 1 : 0) + SB[d]) * BP;
    chk($sformatf("d%0d ready_before_accept", d), ready[d], 1'b1);
    set_din(d, data);
    valid[d] = 1'b1;
    tick();
    if (!hold) valid[d] = 1'b0;
    for (int t = 0; t < len; t++) begin
      if (t == abort_at) begin
        rst = 1'b1;
        tick();
        chk($sformatf("d%0d abort tx", d), tx[d], 1'b1);
        chk($sformatf("d%0d abort busy", d), busy[d], 1'b0);
        chk($sformatf("d%0d abort ready_in_reset", d), ready[d], 1'b0);
        chk($sformatf("d%0d abort done", d), done[d], 1'b0);
        rst = 1'b0;
        #1;
        chk($sformatf("d%0d release ready", d), ready[d], 1'b1);
        chk($sformatf("d%0d release tx", d), tx[d], 1'b1);
        for (int i = 0; i < len; i++) begin
          tick();
          chk($sformatf("d%0d post_abort tx i=%0d", d, i), tx[d], 1'b1);
          chk($sformatf("d%0d post_abort done i=%0d", d, i), done[d], 1'b0);
          chk($sformatf("d%0d post_abort busy i=%0d", d, i), busy[d], 1'b0);
        end
        return;
      end
      chk($sformatf("d%0d tx t=%0d", d, t), tx[d],
          exp_tx(t, data, CH[d], DB[d], PR[d], SB[d]));
      chk($sformatf("d%0d busy t=%0d", d, t), busy[d], 1'b1);
      chk($sformatf("d%0d ready t=%0d", d, t), ready[d], 1'b0);
      chk($sformatf("d%0d done t=%0d", d, t), done[d], 1'b0);
      if (t == 5) set_din(d, {$urandom(), $urandom()});
      tick();
    end
    chk($sformatf("d%0d done_pulse", d), done[d], 1'b1);
    chk($sformatf("d%0d ready_at_end", d), ready[d], 1'b1);
    chk($sformatf("d%0d busy_at_end", d), busy[d], 1'b0);
    chk($sformatf("d%0d tx_at_end", d), tx[d], 1'b1);
    if (!hold) begin
      tick();
      chk($sformatf("d%0d done_one_cycle", d), done[d], 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) tick();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("d%0d reset ready", d), ready[d], 1'b0);
      chk($sformatf("d%0d reset busy", d), busy[d], 1'b0);
      chk($sformatf("d%0d reset tx", d), tx[d], 1'b1);
      chk($sformatf("d%0d reset done", d), done[d], 1'b0);
    end
    rst = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("d%0d after_reset ready", d), ready[d], 1'b1);
      chk($sformatf("d%0d after_reset tx", d), tx[d], 1'b1);
    end
    tick();

    // 8N1 single character, alternating pattern.
    run_xfer(0, 64'h55, 1'b0, -1);
    // i_valid held high: back-to-back transfers one idle cycle apart.
    run_xfer(0, {$urandom(), $urandom()}, 1'b1, -1);
    run_xfer(0, {$urandom(), $urandom()}, 1'b1, -1);
    run_xfer(0, {$urandom(), $urandom()}, 1'b0, -1);

    // Two characters, even parity.
    run_xfer(1, 64'h0301, 1'b0, -1);
    run_xfer(1, {$urandom(), $urandom()}, 1'b0, -1);
    // Reset during data bit 3 of character 1 (bit position 11+1+3).
    run_xfer(1, {$urandom(), $urandom()}, 1'b0, 15 * BP + 1);
    run_xfer(1, {$urandom(), $urandom()}, 1'b0, -1);

    // 7 data bits, odd parity, two stop bits.
    run_xfer(2, 64'h00, 1'b0, -1);
    run_xfer(2, {$urandom(), $urandom()}, 1'b0, -1);
    run_xfer(2, {$urandom(), $urandom()}, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
